test_engine_nic_input_block: RTL

Input stage of the test-engine network interface, on the router-to-node path. It receives one packet (header + `DATA_FLITS` data flits) from the NoC router, assembles it in a single-packet register bank, and launches the processing node with a one-cycle start strobe. Launch is withheld while the node is busy or the output side reports zero credits. Each launch frees the packet buffer and returns one credit to the upstream router.

---
 rtl/test_engine_nic_input_block.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/test_engine_nic_input_block.sv
// Router-to-node input stage: assembles one packet (header + DATA_FLITS data flits) and launches
// the node with a one-cycle strobe. Define NIC_INPUT_PROTOCOL_CHECK_EN for protocol_error_dout.
module test_engine_nic_input_block #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned DATA_FLITS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [FLIT_WIDTH-1:0]            channel_din,
  input  logic                             valid_din,
  input  logic                             zero_credits_din,
  input  logic                             done_strobe_din,
  output logic [FLIT_WIDTH-1:0]            header_dout,
  output logic [DATA_FLITS*FLIT_WIDTH-1:0] data_dout,
  output logic                             start_strobe_dout,
  output logic                             credit_out_dout,
  output logic                             busy_dout
`ifdef NIC_INPUT_PROTOCOL_CHECK_EN
  ,
  output logic                             protocol_error_dout
`endif
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReceive = 2'd1,
    StReady   = 2'd2,
    StStart   = 2'd3
  } state_e;

  localparam logic [2:0] DataFlitsC = 3'(DATA_FLITS);

  state_e                           state_q, state_d;
  logic [2:0]                       cnt_q, cnt_d;
  logic [FLIT_WIDTH-1:0]            header_q, header_d;
  logic [DATA_FLITS*FLIT_WIDTH-1:0] data_q, data_d;
  logic                             busy_q, busy_d;

  logic [2:0] slot;
  logic       busy_eff;
  logic       launch;

  assign slot     = DataFlitsC - cnt_q;
  // A done pulse in the READY cycle frees the node for this evaluation already.
  assign busy_eff = busy_q & ~done_strobe_din;
  assign launch   = (state_q == StReady) & ~zero_credits_din & ~busy_eff;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    header_d = header_q;
    data_d   = data_q;
    unique case (state_q)
      StIdle: begin
        if (valid_din) begin
          header_d = channel_din;
          cnt_d    = DataFlitsC;
          state_d  = StReceive;
        end
      end
      StReceive: begin
        if (valid_din) begin
          for (int unsigned i = 0; i < DATA_FLITS; i++) begin
            if (slot == 3'(i)) begin
              data_d[i*FLIT_WIDTH +: FLIT_WIDTH] = channel_din;
            end
          end
          if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
          end
          if (cnt_q <= 3'd1) begin
            state_d = StReady;
          end
        end
      end
      StReady: begin
        if (launch) begin
          state_d = StStart;
        end
      end
      StStart: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Set wins over a coincident clear.
  always_comb begin
    busy_d = busy_q;
    if (launch) begin
      busy_d = 1'b1;
    end else if (done_strobe_din) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      header_q <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      header_q <= header_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
    end
  end

  assign header_dout       = header_q;
  assign data_dout         = data_q;
  assign start_strobe_dout = (state_q == StStart);
  assign credit_out_dout   = (state_q == StStart);
  assign busy_dout         = busy_q;

`ifdef NIC_INPUT_PROTOCOL_CHECK_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (valid_din && ((state_q == StReady) || (state_q == StStart))) begin
      perr_d = 1'b1;
    end
    if (done_strobe_din && !busy_q) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign protocol_error_dout = perr_q;
`endif

  start_one_cycle_a : assert property (@(posedge clk) disable iff (reset)
    (state_q == StStart) |=> (state_q == StIdle));
  cnt_range_a : assert property (@(posedge clk) disable iff (reset)
    (cnt_q <= DataFlitsC));

endmodule
